// File: rtl/proc_pkg.sv
// Shared processor constants: BTB counter encodings and instruction words used around fetch.
package proc_pkg;

    localparam logic [1:0]  BTB_CNT_SNT = 2'd0;
    localparam logic [1:0]  BTB_CNT_WNT = 2'd1;
    localparam logic [1:0]  BTB_CNT_WT  = 2'd2;
    localparam logic [1:0]  BTB_CNT_ST  = 2'd3;

    localparam logic [4:0]  OPC_BRANCH  = 5'b11000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR  = 32'h000f_0033;

endpackage

// File: rtl/m_sat_counter2.sv
// Combinational next value of a 2-bit saturating direction counter.
module m_sat_counter2
    import proc_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (taken) begin
            if (ctr != BTB_CNT_ST) next = ctr + 2'd1;
        end else begin
            if (ctr != BTB_CNT_SNT) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/m_branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters; lookup from IF, update from MEM,
// plus saturating hit / mispredict statistics for the debug path.
module m_branch_target_buffer
    import proc_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        lookup_en,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] hit_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_LO  = IDX_W + 2;
    localparam int unsigned TAG_HI  = IDX_W + TAG_W + 1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, upd_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag;

    logic               upd_hit, wr_en;
    logic [1:0]         ctr_nxt, wr_ctr;
    logic [31:0]        wr_tgt;

    logic               bypass, rd_valid, lk_hit;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_tgt;
    logic [1:0]         rd_ctr;

    logic               pred_hit_q, pred_hit_d;
    logic               pred_taken_q, pred_taken_d;
    logic [31:0]        pred_target_q, pred_target_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        mis_cnt_q, mis_cnt_d;

    logic               unused_pc_bits;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[TAG_HI:TAG_LO];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[TAG_HI:TAG_LO];

    // Byte offset and PC bits above the tag take no part in prediction.
    assign unused_pc_bits = ^{lookup_pc[31:TAG_HI+1], lookup_pc[1:0],
                              upd_pc[31:TAG_HI+1], upd_pc[1:0]};

    m_sat_counter2 u_upd_ctr (
        .ctr   (ctr_q[upd_idx]),
        .taken (upd_taken),
        .next  (ctr_nxt)
    );

    // A not-taken miss leaves the table alone; a taken miss allocates over any alias.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        wr_en   = ce && upd_en && (upd_hit || upd_taken);
        wr_ctr  = upd_hit ? ctr_nxt : CNT_INIT;
        wr_tgt  = upd_taken ? upd_target : tgt_q[upd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= wr_tgt;
            ctr_q[upd_idx] <= wr_ctr;
        end
    end

    // Write-first read: a same-index update this cycle is forwarded into the lookup.
    always_comb begin
        bypass   = wr_en && (upd_idx == lk_idx);
        rd_valid = bypass ? 1'b1    : valid_q[lk_idx];
        rd_tag   = bypass ? upd_tag : tag_q[lk_idx];
        rd_tgt   = bypass ? wr_tgt  : tgt_q[lk_idx];
        rd_ctr   = bypass ? wr_ctr  : ctr_q[lk_idx];
        lk_hit   = rd_valid && (rd_tag == lk_tag);
    end

    always_comb begin
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        hit_cnt_d     = hit_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        if (ce && lookup_en) begin
            pred_hit_d    = lk_hit;
            pred_taken_d  = lk_hit && rd_ctr[1];
            pred_target_d = lk_hit ? rd_tgt : 32'h0;
            if (lk_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (ce && upd_en && upd_mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'h0;
            hit_cnt_q     <= 32'h0;
            mis_cnt_q     <= 32'h0;
        end else begin
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            hit_cnt_q     <= hit_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign pred_hit       = pred_hit_q;
    assign pred_taken     = pred_taken_q;
    assign pred_target    = pred_target_q;
    assign hit_cnt        = hit_cnt_q;
    assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_m_branch_target_buffer.sv
// Scoreboard bench for m_branch_target_buffer: expected predictions are queued as lookups
// are driven and compared against the registered outputs one cycle later.
module tb_m_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst, ce, lookup_en, upd_en, upd_taken, upd_mispredict;
    logic [31:0] lookup_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target, hit_cnt, mispredict_cnt;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } pred_t;

    pred_t exp_q[$];
    pred_t obs_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    m_branch_target_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .lookup_en      (lookup_en),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .hit_cnt        (hit_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock of stimulus; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input logic c, input logic le, input logic [31:0] lpc,
                        input logic ue, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic um);
        ce = c; lookup_en = le; lookup_pc = lpc;
        upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_mispredict = um;
        @(posedge clk);
        #1;
        if (le) obs_q.push_back(pred_t'{hit: pred_hit, taken: pred_taken, tgt: pred_target});
        ce = 1'b1; lookup_en = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg);
        exp_q.push_back(pred_t'{hit: h, taken: t, tgt: tg});
        step(1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic m);
        step(1'b1, 1'b0, 32'h0, 1'b1, pc, t, tg, m);
    endtask

    task automatic test_reset();
        pred_t e, o;
        rst = 1'b1; ce = 1'b1; lookup_en = 1'b0; upd_en = 1'b0;
        upd_taken = 1'b0; upd_mispredict = 1'b0;
        lookup_pc = 32'h0; upd_pc = 32'h0; upd_target = 32'h0;
        @(posedge clk); #1;
        n_tests++;
        if ({pred_hit, pred_taken, pred_target, hit_cnt, mispredict_cnt} !== 98'h0) begin
            n_fail++;
            $display("FAIL reset_state: hit=%b taken=%b tgt=%h hits=%0d mis=%0d, required all zero",
                     pred_hit, pred_taken, pred_target, hit_cnt, mispredict_cnt);
        end
        rst = 1'b0;
        lookup(32'h40, 1'b0, 1'b0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL reset_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL reset_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_hitcnt: got %0d required 0", hit_cnt); end
    endtask

    task automatic test_alloc();
        pred_t e, o;
        update(32'h40, 1'b1, 32'h20, 1'b0);
        lookup(32'h40, 1'b1, 1'b1, 32'h20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL alloc_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL alloc_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd1) begin n_fail++; $display("FAIL alloc_hitcnt: got %0d required 1", hit_cnt); end
    endtask

    task automatic test_counter_walk();
        pred_t e, o;
        update(32'h40, 1'b0, 32'h0, 1'b0);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup(32'h40, 1'b1, 1'b0, 32'h20);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup(32'h40, 1'b1, 1'b0, 32'h20);
        update(32'h40, 1'b1, 32'h20, 1'b0);
        lookup(32'h40, 1'b1, 1'b0, 32'h20);
        for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 32'h20, 1'b0);
        lookup(32'h40, 1'b1, 1'b1, 32'h20);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup(32'h40, 1'b1, 1'b1, 32'h20);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup(32'h40, 1'b1, 1'b0, 32'h20);
        update(32'h40, 1'b1, 32'h28, 1'b0);
        lookup(32'h40, 1'b1, 1'b1, 32'h28);
        update(32'h40, 1'b0, 32'h99, 1'b0);
        lookup(32'h40, 1'b1, 1'b0, 32'h28);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL walk_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL walk_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd9) begin n_fail++; $display("FAIL walk_hitcnt: got %0d required 9", hit_cnt); end
    endtask

    task automatic test_alias();
        pred_t e, o;
        update(32'h140, 1'b0, 32'h77, 1'b0);
        lookup(32'h40, 1'b1, 1'b0, 32'h28);
        lookup(32'h140, 1'b0, 1'b0, 32'h0);
        update(32'h140, 1'b1, 32'h80, 1'b0);
        lookup(32'h40, 1'b0, 1'b0, 32'h0);
        lookup(32'h140, 1'b1, 1'b1, 32'h80);
        step(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL alias_hold: got hit=%b taken=%b tgt=%h required 1 1 00000080",
                     pred_hit, pred_taken, pred_target);
        end
        lookup(32'h143, 1'b1, 1'b1, 32'h80);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL alias_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL alias_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd12) begin n_fail++; $display("FAIL alias_hitcnt: got %0d required 12", hit_cnt); end
    endtask

    task automatic test_write_first();
        pred_t e, o;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        exp_q.push_back(pred_t'{hit: 1'b1, taken: 1'b1, tgt: 32'h100});
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        exp_q.push_back(pred_t'{hit: 1'b1, taken: 1'b1, tgt: 32'h100});
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 32'h200, 1'b0);
        lookup(32'h44, 1'b1, 1'b1, 32'h200);
        exp_q.push_back(pred_t'{hit: 1'b1, taken: 1'b0, tgt: 32'h100});
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL wfirst_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL wfirst_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd4) begin n_fail++; $display("FAIL wfirst_hitcnt: got %0d required 4", hit_cnt); end
    endtask

    task automatic test_async_reset();
        pred_t e, o;
        update(32'h48, 1'b1, 32'h300, 1'b1);
        update(32'h48, 1'b1, 32'h300, 1'b1);
        lookup(32'h48, 1'b1, 1'b1, 32'h300);
        n_tests++;
        if (mispredict_cnt !== 32'd2) begin
            n_fail++; $display("FAIL mis_cnt: got %0d required 2", mispredict_cnt);
        end
        n_tests++;
        if (hit_cnt !== 32'd5) begin n_fail++; $display("FAIL areset_hitcnt_pre: got %0d required 5", hit_cnt); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({pred_hit, pred_taken, pred_target, hit_cnt, mispredict_cnt} !== 98'h0) begin
            n_fail++;
            $display("FAIL areset_state: hit=%b taken=%b tgt=%h hits=%0d mis=%0d, required all zero",
                     pred_hit, pred_taken, pred_target, hit_cnt, mispredict_cnt);
        end
        #2 rst = 1'b0;
        lookup(32'h40, 1'b0, 1'b0, 32'h0);
        lookup(32'h44, 1'b0, 1'b0, 32'h0);
        lookup(32'h48, 1'b0, 1'b0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL areset_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL areset_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL areset_hitcnt: got %0d required 0", hit_cnt); end
    endtask

    task automatic test_clock_enable();
        pred_t e, o;
        update(32'h40, 1'b1, 32'h10, 1'b0);
        lookup(32'h40, 1'b1, 1'b1, 32'h10);
        exp_q.push_back(pred_t'{hit: 1'b1, taken: 1'b1, tgt: 32'h10});
        step(1'b0, 1'b1, 32'h44, 1'b1, 32'h44, 1'b1, 32'h500, 1'b1);
        exp_q.push_back(pred_t'{hit: 1'b1, taken: 1'b1, tgt: 32'h10});
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        lookup(32'h44, 1'b0, 1'b0, 32'h0);
        lookup(32'h40, 1'b1, 1'b1, 32'h10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL ce_pred: no observation"); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL ce_pred: got %h required %h", o, e); end
            end
        end
        n_tests++;
        if (hit_cnt !== 32'd2) begin n_fail++; $display("FAIL ce_hitcnt: got %0d required 2", hit_cnt); end
        n_tests++;
        if (mispredict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL ce_miscnt: got %0d required 0", mispredict_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter_walk();
        test_alias();
        test_write_first();
        test_async_reset();
        test_clock_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
